// File: rtl/integrator_sequencer_if.sv
// integrator_sequencer_if: control and status bundle
// between the sequencer and the threshold integrator.
interface integrator_sequencer_if;
  logic        integ_resetn;
  logic        integ_enable;
  logic [31:0] integ_window;
  logic [14:0] integ_threshold;
  logic        integ_setup_done;
  logic        integ_over_threshold;
  logic        integ_err_overflow;
  logic        integ_err_underflow;

  modport master (
    output integ_resetn,
    output integ_enable,
    output integ_window,
    output integ_threshold,
    input  integ_setup_done,
    input  integ_over_threshold,
    input  integ_err_overflow,
    input  integ_err_underflow
  );

  modport slave (
    input  integ_resetn,
    input  integ_enable,
    input  integ_window,
    input  integ_threshold,
    output integ_setup_done,
    output integ_over_threshold,
    output integ_err_overflow,
    output integ_err_underflow
  );
endinterface

// File: rtl/integrator_sequencer.sv
// integrator_sequencer: arm/setup/run/disarm sequencing
// and sticky fault supervision for the integrator.
module integrator_sequencer #(
  parameter int unsigned RESET_CYCLES  = 4,
  parameter int unsigned SETUP_TIMEOUT = 1000000
) (
  input  logic                          clk,
  input  logic                          aresetn,
  input  logic [31:0]                   cfg_window,
  input  logic [14:0]                   cfg_threshold,
  input  logic                          arm,
  input  logic                          disarm,
  input  logic                          clear_fault,
  integrator_sequencer_if.master        integ,
  output logic                          running,
  output logic                          fault,
  output logic [2:0]                    fault_code,
  output logic                          shutdown_req
);

  localparam logic [2:0] S_FLUSH = 3'd0;
  localparam logic [2:0] S_IDLE  = 3'd1;
  localparam logic [2:0] S_CHECK = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_RUN   = 3'd4;
  localparam logic [2:0] S_FAULT = 3'd5;

  localparam logic [7:0]  FLUSH_LOAD = 8'(RESET_CYCLES - 1);
  localparam logic [31:0] TMO_LAST   = 32'(SETUP_TIMEOUT - 1);

  logic [2:0]  state;
  logic [7:0]  flush_cnt;
  logic [31:0] tmo_cnt;
  logic        flag_hit;
  logic [2:0]  flag_code;

  // Integrator error flags ranked: overflow, underflow, over-threshold
  always_comb begin
    flag_hit  = 1'b1;
    flag_code = 3'd0;
    priority case (1'b1)
      integ.integ_err_overflow:   flag_code = 3'd5;
      integ.integ_err_underflow:  flag_code = 3'd6;
      integ.integ_over_threshold: flag_code = 3'd4;
      default:                    flag_hit  = 1'b0;
    endcase
  end

  // Sequencer state, counters and all registered outputs
  always_ff @(posedge clk) begin
    if (!aresetn) begin
      state                 <= S_FLUSH;
      flush_cnt             <= FLUSH_LOAD;
      tmo_cnt               <= 32'd0;
      integ.integ_resetn    <= 1'b0;
      integ.integ_enable    <= 1'b0;
      integ.integ_window    <= 32'd0;
      integ.integ_threshold <= 15'd0;
      running               <= 1'b0;
      fault                 <= 1'b0;
      fault_code            <= 3'd0;
      shutdown_req          <= 1'b0;
    end else begin
      unique case (state)
        S_FLUSH: begin
          integ.integ_resetn <= 1'b0;
          integ.integ_enable <= 1'b0;
          if (flush_cnt == 8'd0) begin
            state <= S_IDLE;
          end else begin
            flush_cnt <= flush_cnt - 8'd1;
          end
        end
        S_IDLE: begin
          integ.integ_resetn <= 1'b0;
          if (arm) begin
            integ.integ_window    <= cfg_window;
            integ.integ_threshold <= cfg_threshold;
            state                 <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (integ.integ_window[31:11] == 21'd0) begin
            state        <= S_FAULT;
            fault        <= 1'b1;
            shutdown_req <= 1'b1;
            fault_code   <= 3'd1;
          end else if (integ.integ_threshold == 15'd0) begin
            state        <= S_FAULT;
            fault        <= 1'b1;
            shutdown_req <= 1'b1;
            fault_code   <= 3'd2;
          end else begin
            state              <= S_WAIT;
            tmo_cnt            <= 32'd0;
            integ.integ_resetn <= 1'b1;
            integ.integ_enable <= 1'b1;
          end
        end
        S_WAIT: begin
          tmo_cnt <= tmo_cnt + 32'd1;
          if (flag_hit) begin
            state              <= S_FAULT;
            fault              <= 1'b1;
            shutdown_req       <= 1'b1;
            fault_code         <= flag_code;
            integ.integ_enable <= 1'b0;
          end else if (disarm) begin
            state              <= S_FLUSH;
            flush_cnt          <= FLUSH_LOAD;
            integ.integ_resetn <= 1'b0;
            integ.integ_enable <= 1'b0;
          end else if (integ.integ_setup_done) begin
            state   <= S_RUN;
            running <= 1'b1;
          end else if (tmo_cnt == TMO_LAST) begin
            state              <= S_FAULT;
            fault              <= 1'b1;
            shutdown_req       <= 1'b1;
            fault_code         <= 3'd3;
            integ.integ_enable <= 1'b0;
          end
        end
        S_RUN: begin
          if (flag_hit) begin
            state              <= S_FAULT;
            fault              <= 1'b1;
            shutdown_req       <= 1'b1;
            fault_code         <= flag_code;
            integ.integ_enable <= 1'b0;
            running            <= 1'b0;
          end else if (disarm) begin
            state              <= S_FLUSH;
            flush_cnt          <= FLUSH_LOAD;
            integ.integ_resetn <= 1'b0;
            integ.integ_enable <= 1'b0;
            running            <= 1'b0;
          end
        end
        S_FAULT: begin
          integ.integ_enable <= 1'b0;
          if (clear_fault) begin
            state              <= S_FLUSH;
            flush_cnt          <= FLUSH_LOAD;
            integ.integ_resetn <= 1'b0;
            fault              <= 1'b0;
            shutdown_req       <= 1'b0;
            fault_code         <= 3'd0;
          end
        end
        default: begin
          state              <= S_FLUSH;
          flush_cnt          <= FLUSH_LOAD;
          integ.integ_resetn <= 1'b0;
          integ.integ_enable <= 1'b0;
          running            <= 1'b0;
        end
      endcase
    end
  end

endmodule
